// File: rtl/vcdl_delay_scan.sv
// Multi-channel VCDL delay control: owns the IDELAY tap value and load strobe
// per channel, supports manual tap loads and an autonomous tap scan that finds
// the tap where a channel's feedback sample changes level, then applies it
// plus a fixed offset (saturated at the maximum tap).
module vcdl_delay_scan #(
    parameter int unsigned NUM_CH        = 4,
    parameter int unsigned CH_BITS       = 2,
    parameter int unsigned TAP_BITS      = 5,
    parameter int unsigned SETTLE_CYCLES = 8,
    parameter int unsigned SAMPLE_LOG2   = 4,
    parameter int unsigned OFFSET        = 0
) (
    input  logic                         sysclk_i,
    input  logic                         rst_n_i,
    input  logic [CH_BITS-1:0]           ch_sel_i,
    input  logic [TAP_BITS-1:0]          manual_val_i,
    input  logic                         manual_ld_i,
    input  logic                         scan_start_i,
    input  logic [NUM_CH-1:0]            fb_q_i,
    output logic [NUM_CH*TAP_BITS-1:0]   delay_o,
    output logic [NUM_CH-1:0]            load_o,
    output logic                         busy_o,
    output logic                         done_o,
    output logic                         found_o,
    output logic [TAP_BITS-1:0]          edge_tap_o
);

    localparam int unsigned SET_W   = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int unsigned ACC_W   = SAMPLE_LOG2 + 1;
    localparam int unsigned TAP_MAX = (1 << TAP_BITS) - 1;
    localparam int unsigned OFS_SAT = (OFFSET > TAP_MAX) ? TAP_MAX : OFFSET;

    localparam logic [TAP_BITS-1:0] MAX_TAP     = '1;
    localparam logic [ACC_W-1:0]    THRESH      = ACC_W'(1) << (SAMPLE_LOG2 - 1);
    localparam logic [SET_W-1:0]    SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [TAP_BITS:0]   OFFSET_W    = (TAP_BITS + 1)'(OFS_SAT);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StSettle,
        StSample,
        StEval,
        StApply,
        StDone
    } state_e;

    state_e                       state_q;
    logic [NUM_CH-1:0]            ch_oh_q;
    logic [TAP_BITS-1:0]          tap_q;
    logic [TAP_BITS-1:0]          saved_q;
    logic                         prev_high_q;
    logic [SET_W-1:0]             settle_q;
    logic [SAMPLE_LOG2-1:0]       sample_q;
    logic [ACC_W-1:0]             acc_q;
    logic [NUM_CH*TAP_BITS-1:0]   delay_q;
    logic [NUM_CH-1:0]            load_q;
    logic                         busy_q;
    logic                         done_q;
    logic                         found_q;
    logic [TAP_BITS-1:0]          edge_tap_q;

    logic [NUM_CH-1:0]            sel_oh;
    logic [TAP_BITS-1:0]          sel_tap;
    logic                         cmd_ok;
    logic                         fb_bit;
    logic                         high;
    logic                         edge_hit;
    logic [TAP_BITS:0]            sum;
    logic [TAP_BITS-1:0]          apply_tap;

    // Replace the tap slices selected by a one-hot channel mask.
    function automatic logic [NUM_CH*TAP_BITS-1:0] put_tap(
        input logic [NUM_CH*TAP_BITS-1:0] vec,
        input logic [NUM_CH-1:0]          oh,
        input logic [TAP_BITS-1:0]        val
    );
        logic [NUM_CH*TAP_BITS-1:0] res;
        res = vec;
        for (int c = 0; c < NUM_CH; c++) begin
            if (oh[c]) res[c*TAP_BITS +: TAP_BITS] = val;
        end
        return res;
    endfunction

    // Channel decode, current-tap lookup, feedback select and edge arithmetic.
    always_comb begin
        sel_oh  = '0;
        sel_tap = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            sel_oh[c] = (ch_sel_i == CH_BITS'(c));
            if (sel_oh[c]) sel_tap = delay_q[c*TAP_BITS +: TAP_BITS];
        end
        // An out-of-range select decodes to an empty mask and is ignored.
        cmd_ok    = |sel_oh;
        fb_bit    = |(fb_q_i & ch_oh_q);
        high      = (acc_q >= THRESH);
        edge_hit  = (tap_q != '0) && (high != prev_high_q);
        sum       = {1'b0, tap_q} + OFFSET_W;
        apply_tap = (sum > {1'b0, MAX_TAP}) ? MAX_TAP : sum[TAP_BITS-1:0];
    end

    // Scan FSM with all outputs registered; strobes default low each cycle.
    always_ff @(posedge sysclk_i) begin
        if (!rst_n_i) begin
            state_q     <= StIdle;
            ch_oh_q     <= '0;
            tap_q       <= '0;
            saved_q     <= '0;
            prev_high_q <= 1'b0;
            settle_q    <= '0;
            sample_q    <= '0;
            acc_q       <= '0;
            delay_q     <= '0;
            load_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            found_q     <= 1'b0;
            edge_tap_q  <= '0;
        end else begin
            load_q <= '0;
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    // A scan request wins over a simultaneous manual load.
                    if (scan_start_i && cmd_ok) begin
                        ch_oh_q    <= sel_oh;
                        saved_q    <= sel_tap;
                        tap_q      <= '0;
                        acc_q      <= '0;
                        busy_q     <= 1'b1;
                        found_q    <= 1'b0;
                        edge_tap_q <= '0;
                        delay_q    <= put_tap(delay_q, sel_oh, '0);
                        load_q     <= sel_oh;
                        state_q    <= StLoad;
                    end else if (manual_ld_i && cmd_ok) begin
                        delay_q <= put_tap(delay_q, sel_oh, manual_val_i);
                        load_q  <= sel_oh;
                    end
                end
                StLoad: begin
                    settle_q <= '0;
                    state_q  <= StSettle;
                end
                StSettle: begin
                    if (settle_q == SETTLE_LAST) begin
                        sample_q <= '0;
                        state_q  <= StSample;
                    end else begin
                        settle_q <= settle_q + 1'b1;
                    end
                end
                StSample: begin
                    acc_q    <= acc_q + ACC_W'(fb_bit);
                    sample_q <= sample_q + 1'b1;
                    if (sample_q == '1) state_q <= StEval;
                end
                StEval: begin
                    load_q <= ch_oh_q;
                    if (edge_hit) begin
                        found_q    <= 1'b1;
                        edge_tap_q <= tap_q;
                        delay_q    <= put_tap(delay_q, ch_oh_q, apply_tap);
                        state_q    <= StApply;
                    end else begin
                        prev_high_q <= high;
                        if (tap_q == MAX_TAP) begin
                            // No transition anywhere: restore the pre-scan tap.
                            delay_q <= put_tap(delay_q, ch_oh_q, saved_q);
                            state_q <= StApply;
                        end else begin
                            tap_q   <= tap_q + 1'b1;
                            acc_q   <= '0;
                            delay_q <= put_tap(delay_q, ch_oh_q, tap_q + 1'b1);
                            state_q <= StLoad;
                        end
                    end
                end
                StApply: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= StDone;
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign delay_o    = delay_q;
    assign load_o     = load_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign found_o    = found_q;
    assign edge_tap_o = edge_tap_q;

endmodule

// File: tb/tb_vcdl_delay_scan.sv
// Self-checking bench for vcdl_delay_scan: feedback is generated from a
// per-channel, per-tap ones-density table, and expected scan results come from
// a plain search for the first tap whose majority level differs from its
// predecessor.
module tb_vcdl_delay_scan;

    localparam int NCH = 4;
    localparam int CHB = 3;
    localparam int TB  = 5;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [CHB-1:0]    ch_sel;
    logic [TB-1:0]     manual_val;
    logic              manual_ld;
    logic              scan_start;
    logic [NCH-1:0]    fb;
    logic [NCH*TB-1:0] delay;
    logic [NCH-1:0]    load;
    logic              busy;
    logic              done;
    logic              found;
    logic [TB-1:0]     edge_tap;

    int          n_cmp = 0;
    int          n_err = 0;
    int unsigned cyc   = 0;
    int          fb_n [NCH][32];   // ones per 16-sample window, per channel and tap
    logic [TB-1:0] exp_delay [NCH];

    vcdl_delay_scan #(
        .NUM_CH       (NCH),
        .CH_BITS      (CHB),
        .TAP_BITS     (TB),
        .SETTLE_CYCLES(8),
        .SAMPLE_LOG2  (4),
        .OFFSET       (3)
    ) dut (
        .sysclk_i    (clk),
        .rst_n_i     (rst_n),
        .ch_sel_i    (ch_sel),
        .manual_val_i(manual_val),
        .manual_ld_i (manual_ld),
        .scan_start_i(scan_start),
        .fb_q_i      (fb),
        .delay_o     (delay),
        .load_o      (load),
        .busy_o      (busy),
        .done_o      (done),
        .found_o     (found),
        .edge_tap_o  (edge_tap)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Period-16 pattern: any 16 consecutive samples hold exactly fb_n ones.
    always @(negedge clk) begin
        for (int c = 0; c < NCH; c++) begin
            fb[c] <= ((cyc % 16) < 32'(fb_n[c][int'(delay[c*TB +: TB])]));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NCH*TB-1:0] model_vec();
        logic [NCH*TB-1:0] v;
        for (int c = 0; c < NCH; c++) v[c*TB +: TB] = exp_delay[c];
        return v;
    endfunction

    // First tap whose majority level differs from the previous tap, or -1.
    function automatic int model_edge(input int c);
        for (int t = 1; t < 32; t++) begin
            if ((fb_n[c][t] >= 8) != (fb_n[c][t-1] >= 8)) return t;
        end
        return -1;
    endfunction

    task automatic fill_noise(input int c);
        for (int t = 0; t < 32; t++) fb_n[c][t] = $urandom_range(0, 16);
    endtask

    task automatic gen_pattern(input int c);
        int e;
        int inv;
        int lvl;
        e   = $urandom_range(1, 36);
        inv = $urandom_range(0, 1);
        for (int t = 0; t < 32; t++) begin
            lvl = ((t >= e) ? 1 : 0) ^ inv;
            fb_n[c][t] = lvl ? $urandom_range(8, 16) : $urandom_range(0, 7);
        end
    endtask

    task automatic do_manual(input int c, input int val);
        ch_sel     = CHB'(c);
        manual_val = TB'(val);
        manual_ld  = 1'b1;
        tick();
        manual_ld  = 1'b0;
        exp_delay[c] = TB'(val);
        n_cmp++;
        if (delay !== model_vec() || load !== NCH'(1 << c)) begin
            n_err++;
            $display("FAIL manual_load ch%0d: delay=%h load=%b want delay=%h load=%b",
                     c, delay, load, model_vec(), NCH'(1 << c));
        end
        tick();
        n_cmp++;
        if (load !== '0) begin
            n_err++;
            $display("FAIL manual_load_pulse ch%0d: load=%b want 0000", c, load);
        end
    endtask

    task automatic scan_scenario(input int c, input bit poke, input bit with_manual);
        int e, last_tap, exp_n, exp_final, n, loads, last_load, other, busy_drop;
        logic [TB-1:0] last_val;
        e         = model_edge(c);
        last_tap  = (e >= 0) ? e : 31;
        exp_n     = 26 * (last_tap + 1) + 2;
        exp_final = (e >= 0) ? ((e + 3 > 31) ? 31 : e + 3) : int'(exp_delay[c]);
        ch_sel     = CHB'(c);
        scan_start = 1'b1;
        manual_ld  = with_manual;
        manual_val = 5'd23;
        tick();
        scan_start = 1'b0;
        manual_ld  = 1'b0;
        n = 1;
        n_cmp++;
        if (busy !== 1'b1 || found !== 1'b0 || edge_tap !== '0) begin
            n_err++;
            $display("FAIL scan_start_flags ch%0d: busy=%b found=%b edge=%0d want 1 0 0",
                     c, busy, found, edge_tap);
        end
        n_cmp++;
        if (load !== NCH'(1 << c) || delay[c*TB +: TB] !== '0) begin
            n_err++;
            $display("FAIL scan_first_load ch%0d: load=%b tap=%0d want load=%b tap=0",
                     c, load, delay[c*TB +: TB], NCH'(1 << c));
        end
        loads = 1; last_load = 1; last_val = '0; other = 0; busy_drop = 0;
        while (done !== 1'b1 && n < 1000) begin
            if (poke && n == 40) begin
                ch_sel     = CHB'((c + 1) % NCH);
                manual_val = 5'd7;
                manual_ld  = 1'b1;
                scan_start = 1'b1;
            end else begin
                manual_ld  = 1'b0;
                scan_start = 1'b0;
            end
            tick();
            n++;
            if (load[c]) begin
                loads++;
                last_load = n;
                last_val  = delay[c*TB +: TB];
            end
            if ((load & ~NCH'(1 << c)) != '0) other++;
            if (done !== 1'b1 && busy !== 1'b1) busy_drop++;
        end
        manual_ld  = 1'b0;
        scan_start = 1'b0;
        n_cmp++;
        if (done !== 1'b1 || n != exp_n) begin
            n_err++;
            $display("FAIL scan_done_time ch%0d: done=%b at %0d want 1 at %0d", c, done, n, exp_n);
        end
        n_cmp++;
        if (found !== (e >= 0) || edge_tap !== TB'((e >= 0) ? e : 0) || busy !== 1'b0) begin
            n_err++;
            $display("FAIL scan_result ch%0d: found=%b edge=%0d busy=%b want %b %0d 0",
                     c, found, edge_tap, busy, (e >= 0), (e >= 0) ? e : 0);
        end
        n_cmp++;
        if (last_load != n - 1 || last_val !== TB'(exp_final)) begin
            n_err++;
            $display("FAIL scan_apply ch%0d: load@%0d tap=%0d want load@%0d tap=%0d",
                     c, last_load, last_val, n - 1, exp_final);
        end
        n_cmp++;
        if (loads != last_tap + 2 || other != 0 || busy_drop != 0) begin
            n_err++;
            $display("FAIL scan_strobes ch%0d: loads=%0d other=%0d busydrop=%0d want %0d 0 0",
                     c, loads, other, busy_drop, last_tap + 2);
        end
        exp_delay[c] = TB'(exp_final);
        n_cmp++;
        if (delay !== model_vec()) begin
            n_err++;
            $display("FAIL scan_delays ch%0d: delay=%h want %h", c, delay, model_vec());
        end
        tick();
        n_cmp++;
        if (done !== 1'b0 || load !== '0) begin
            n_err++;
            $display("FAIL scan_done_pulse ch%0d: done=%b load=%b want 0 0000", c, done, load);
        end
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        n_cmp++;
        if ({delay, load, busy, done, found, edge_tap} !== '0) begin
            n_err++;
            $display("FAIL reset_state: delay=%h load=%b busy=%b done=%b found=%b edge=%0d want 0",
                     delay, load, busy, done, found, edge_tap);
        end
        rst_n = 1'b1;
        for (int c = 0; c < NCH; c++) exp_delay[c] = '0;
        tick();
    endtask

    task automatic test_manual_load();
        do_manual(2, 17);
        for (int i = 0; i < 6; i++) do_manual($urandom_range(0, NCH - 1), $urandom_range(0, 31));
    endtask

    task automatic test_out_of_range();
        for (int s = NCH; s < 8; s++) begin
            ch_sel     = CHB'(s);
            manual_val = 5'd11;
            manual_ld  = 1'b1;
            scan_start = (s != NCH);
            tick();
            manual_ld  = 1'b0;
            scan_start = 1'b0;
            n_cmp++;
            if (load !== '0 || busy !== 1'b0 || done !== 1'b0 || delay !== model_vec()) begin
                n_err++;
                $display("FAIL out_of_range ch%0d: load=%b busy=%b delay=%h want 0000 0 %h",
                         s, load, busy, delay, model_vec());
            end
        end
        tick();
    endtask

    task automatic test_scan_edge();
        for (int c = 0; c < NCH; c++) fill_noise(c);
        for (int t = 0; t < 32; t++) fb_n[1][t] = (t >= 13) ? 16 : 0;
        scan_scenario(1, 1'b0, 1'b0);
    endtask

    task automatic test_no_edge();
        do_manual(0, 9);
        for (int t = 0; t < 32; t++) fb_n[0][t] = 16;
        scan_scenario(0, 1'b0, 1'b0);
    endtask

    task automatic test_threshold_saturation();
        for (int t = 0; t < 32; t++) fb_n[2][t] = (t == 30) ? 8 : ((t == 31) ? 16 : 0);
        scan_scenario(2, 1'b0, 1'b0);
    endtask

    task automatic test_request_filtering();
        gen_pattern(3);
        scan_scenario(3, 1'b1, 1'b1);
    endtask

    task automatic test_reset_mid_scan();
        for (int t = 0; t < 32; t++) fb_n[1][t] = (t >= 20) ? 16 : 0;
        ch_sel     = CHB'(1);
        scan_start = 1'b1;
        tick();
        scan_start = 1'b0;
        for (int i = 1; i < 100; i++) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < NCH; c++) exp_delay[c] = '0;
        n_cmp++;
        if ({delay, load, busy, done, found, edge_tap} !== '0) begin
            n_err++;
            $display("FAIL reset_mid_scan: delay=%h load=%b busy=%b done=%b found=%b edge=%0d",
                     delay, load, busy, done, found, edge_tap);
        end
        tick();
        n_cmp++;
        if (busy !== 1'b0 || load !== '0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL reset_idle: busy=%b load=%b done=%b want 0 0000 0", busy, load, done);
        end
        scan_scenario(1, 1'b0, 1'b0);
    endtask

    task automatic test_random_scans();
        int c;
        for (int i = 0; i < 4; i++) begin
            c = $urandom_range(0, NCH - 1);
            for (int k = 0; k < NCH; k++) fill_noise(k);
            gen_pattern(c);
            scan_scenario(c, 1'b0, 1'b0);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        ch_sel     = '0;
        manual_val = '0;
        manual_ld  = 1'b0;
        scan_start = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            exp_delay[c] = '0;
            for (int t = 0; t < 32; t++) fb_n[c][t] = 0;
        end
        test_reset();
        test_manual_load();
        test_out_of_range();
        test_scan_edge();
        test_no_edge();
        test_threshold_saturation();
        test_request_filtering();
        test_reset_mid_scan();
        test_random_scans();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
